fetch_unit: RTL

- Instruction fetch stage that sits directly upstream of the IF/ID pipeline register in the pipelined RISC-V core.
- Owns the program counter and issues requests to instruction memory over a request/ack/response handshake, so memory latency can vary.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode under a valid/ready handshake.
- Applies branch redirects from EX/MEM by flushing the buffer and restarting fetch at the target.

---
 rtl/fetch_unit_if.sv | 38 +++
 rtl/fetch_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory request/ack/response handshake
// plus the valid/ready link into the IF/ID pipeline register.
// The fetch unit uses the master side; memory and decode sit on the slave side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rvalid,
    input  imem_rdata,
    input  id_ready,
    output if_valid,
    output if_pc,
    output if_instr
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rvalid,
    output imem_rdata,
    output id_ready,
    input  if_valid,
    input  if_pc,
    input  if_instr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the IF/ID register of the pipelined RISC-V core.
// Owns the PC, keeps at most one instruction-memory request in flight, buffers
// returned words with their PCs in a small FIFO, and restarts at branch targets
// coming back from EX/MEM. A request already issued to memory when a redirect
// arrives cannot be withdrawn, so its response is remembered as stale and dropped.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  fetch_unit_if.master bus,
  output logic [31:0] fetch_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic               discard_q, discard_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]        pc_mem_q [DEPTH];
  logic [31:0]        pc_mem_d [DEPTH];
  logic [31:0]        instr_mem_q [DEPTH];
  logic [31:0]        instr_mem_d [DEPTH];
  logic [31:0]        head_pc_q, head_pc_d;
  logic [31:0]        head_instr_q, head_instr_d;

  logic [31:0]        redirect_target;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   remaining;

  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // Request sequencing: issue one fetch, wait for its response, and track
  // whether the outstanding response has been made stale by a redirect.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    discard_d  = discard_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q < CNT_W'(DEPTH)) begin
          state_d    = REQ;
          req_addr_d = redirect ? redirect_target : fetch_pc_q;
        end
      end
      REQ: begin
        if (bus.imem_ack) begin
          state_d = WAIT;
          if (!discard_q) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
        if (redirect) begin
          discard_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          push      = !discard_q && !redirect;
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (redirect) begin
      fetch_pc_d = redirect_target;
    end
  end

  // Instruction buffer bookkeeping: push responses, pop into decode, flush on
  // redirect, and precompute the head entry so the outputs come straight from flops.
  always_comb begin
    pc_mem_d     = pc_mem_q;
    instr_mem_d  = instr_mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    pop          = (count_q != '0) && bus.id_ready && !redirect;
    remaining    = count_q - CNT_W'(pop);

    if (push) begin
      pc_mem_d[wr_ptr_q]    = req_addr_q;
      instr_mem_d[wr_ptr_q] = bus.imem_rdata;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = remaining + CNT_W'(push);

    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end

    if (count_d != '0) begin
      if (push && (remaining == '0)) begin
        head_pc_d    = req_addr_q;
        head_instr_d = bus.imem_rdata;
      end else begin
        head_pc_d    = pc_mem_q[rd_ptr_d];
        head_instr_d = instr_mem_q[rd_ptr_d];
      end
    end
  end

  // Control state and PC registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      discard_q  <= discard_d;
    end
  end

  // Buffer storage, pointers, occupancy and the registered head entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      head_pc_q    <= 32'h0;
      head_instr_q <= 32'h0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= 32'h0;
        instr_mem_q[i] <= 32'h0;
      end
    end else begin
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= pc_mem_d[i];
        instr_mem_q[i] <= instr_mem_d[i];
      end
    end
  end

  assign bus.imem_req  = (state_q == REQ);
  assign bus.imem_addr = (state_q == REQ) ? req_addr_q : fetch_pc_q;
  assign bus.if_valid  = (count_q != '0);
  assign bus.if_pc     = head_pc_q;
  assign bus.if_instr  = head_instr_q;
  assign fetch_pc      = fetch_pc_q;

endmodule
